result_vector_collector: RTL and testbench

RESULT_VECTOR_COLLECTOR -- requirements
Module: result_vector_collector

---
 rtl/result_vector_collector_pkg.sv | 16 +
 rtl/result_vector_collector_if.sv | 29 ++
 rtl/result_buffer_1w1r.sv | 44 ++++
 rtl/result_vector_collector.sv | 110 +++++++++++
 tb/tb_result_vector_collector.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/result_vector_collector_pkg.sv
// Shared constants and state encoding for the row organizer stages.
// Imported by the result vector collector and its buffer.
package result_vector_collector_pkg;

  localparam int ELEMENT_WIDTH = 32;
  localparam int NO_OF_ROWS    = 16;
  localparam int IDX_WIDTH     = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } rvc_state_t;

endpackage

// File: rtl/result_vector_collector_if.sv
// Drain-side valid/ready handshake of the result vector collector.
// master drives data/index/valid, slave returns ready.
interface result_vector_collector_if
  import result_vector_collector_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int idx_width     = IDX_WIDTH
);

  logic [element_width-1:0] out_data;
  logic [idx_width-1:0]     out_index;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/result_buffer_1w1r.sv
// Row result storage: one sync write port, one registered read port,
// one combinational read port used by the drain path.
module result_buffer_1w1r
  import result_vector_collector_pkg::*;
#(
  parameter int width = ELEMENT_WIDTH,
  parameter int depth = NO_OF_ROWS,
  parameter int aw    = IDX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata,
  input  logic [aw-1:0]    daddr,
  output logic [width-1:0] ddata
);

  localparam logic [aw:0] DEPTH_W = (aw+1)'(depth);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read samples mem before this edge's write lands: read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if ({1'b0, raddr} < DEPTH_W) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

  assign ddata = mem[daddr];

endmodule

// File: rtl/result_vector_collector.sv
// Collects one vector of row dot products, then drains it in row order
// over a valid/ready port while allowing random-access reads.
module result_vector_collector
  import result_vector_collector_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_rows    = NO_OF_ROWS,
  parameter int idx_width     = IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     main_reset,
  input  logic                     start,
  input  logic [element_width-1:0] adder_output,
  input  logic                     final_adder_finish_dash,
  result_vector_collector_if.master drn,
  input  logic [idx_width-1:0]     rd_addr,
  output logic [element_width-1:0] rd_data,
  output logic [idx_width:0]       row_count,
  output logic                     vector_done,
  output logic                     overflow_error
);

  localparam logic [idx_width:0]   LAST_CNT = (idx_width+1)'(no_of_rows-1);
  localparam logic [idx_width-1:0] LAST_PTR = idx_width'(no_of_rows-1);

  rvc_state_t               state;
  logic [idx_width-1:0]     drain_ptr;
  logic                     valid_q;
  logic [element_width-1:0] drain_data;
  logic                     wr_en;
  logic                     fin;

  assign fin   = final_adder_finish_dash;
  assign wr_en = start && (state == COLLECT) && fin;

  result_buffer_1w1r #(
    .width (element_width),
    .depth (no_of_rows),
    .aw    (idx_width)
  ) u_buf (
    .clk   (clk),
    .rst   (main_reset),
    .we    (wr_en),
    .waddr (row_count[idx_width-1:0]),
    .wdata (adder_output),
    .raddr (rd_addr),
    .rdata (rd_data),
    .daddr (drain_ptr),
    .ddata (drain_data)
  );

  // Gating on valid keeps the outputs at zero while the buffer is unwritten.
  assign drn.out_valid = valid_q;
  assign drn.out_data  = valid_q ? drain_data : '0;
  assign drn.out_index = valid_q ? drain_ptr : '0;

  always_ff @(posedge clk or posedge main_reset) begin
    if (main_reset) begin
      state          <= IDLE;
      row_count      <= '0;
      drain_ptr      <= '0;
      valid_q        <= 1'b0;
      vector_done    <= 1'b0;
      overflow_error <= 1'b0;
    end else if (!start) begin
      state       <= IDLE;
      valid_q     <= 1'b0;
      vector_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state          <= COLLECT;
          row_count      <= '0;
          drain_ptr      <= '0;
          overflow_error <= 1'b0;
        end
        COLLECT: begin
          if (fin) begin
            row_count <= row_count + 1'b1;
            if (row_count == LAST_CNT) begin
              state   <= DRAIN;
              valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fin) begin
            overflow_error <= 1'b1;
          end
          if (valid_q && drn.out_ready) begin
            if (drain_ptr == LAST_PTR) begin
              state       <= DONE;
              valid_q     <= 1'b0;
              vector_done <= 1'b1;
            end else begin
              drain_ptr <= drain_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          if (fin) begin
            overflow_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_vector_collector.sv
// Directed bench for result_vector_collector: table-driven reads plus
// hand-written capture, drain, overflow, abort and reset sequences.
module tb_result_vector_collector;

  localparam int EW  = 32;
  localparam int NR  = 16;
  localparam int IW  = 5;

  logic          clk = 1'b0;
  logic          main_reset;
  logic          start;
  logic [EW-1:0] adder_output;
  logic          fin;
  logic [IW-1:0] rd_addr;
  logic [EW-1:0] rd_data;
  logic [IW:0]   row_count;
  logic          vector_done;
  logic          overflow_error;

  int total = 0;
  int bad   = 0;

  result_vector_collector_if #(
    .element_width (EW),
    .idx_width     (IW)
  ) drn_if ();

  result_vector_collector #(
    .element_width (EW),
    .no_of_rows    (NR),
    .idx_width     (IW)
  ) dut (
    .clk                     (clk),
    .main_reset              (main_reset),
    .start                   (start),
    .adder_output            (adder_output),
    .final_adder_finish_dash (fin),
    .drn                     (drn_if.master),
    .rd_addr                 (rd_addr),
    .rd_data                 (rd_data),
    .row_count               (row_count),
    .vector_done             (vector_done),
    .overflow_error          (overflow_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] addr;
    logic [EW-1:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic collect(input int n, input logic [EW-1:0] base);
    for (int i = 0; i < n; i++) begin
      adder_output = base + EW'(i);
      fin = 1'b1;
      tick();
    end
    fin = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0,...
  task automatic drain(input logic [EW-1:0] base, input int mode);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < NR && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      drn_if.out_ready = rdy;
      check("drain_valid", drn_if.out_valid, 1);
      check("drain_data", drn_if.out_data, base + EW'(idx));
      check("drain_index", drn_if.out_index, idx);
      tick();
      if (rdy) idx++;
      cyc++;
    end
    if (idx < NR) begin
      bad++;
      $display("FAIL drain_budget got=%0d want=%0d", idx, NR);
    end
    drn_if.out_ready = 1'b0;
    check("done_valid", drn_if.out_valid, 0);
    check("done_flag", vector_done, 1);
  endtask

  initial begin
    rd_tab[0] = '{5'd0,  32'h3F80_0000};
    rd_tab[1] = '{5'd3,  32'h3F80_0003};
    rd_tab[2] = '{5'd9,  32'h3F80_0009};
    rd_tab[3] = '{5'd15, 32'h3F80_000F};
    rd_tab[4] = '{5'd16, 32'h0};
    rd_tab[5] = '{5'd20, 32'h0};
    rd_tab[6] = '{5'd31, 32'h0};

    main_reset = 1'b1;
    start = 1'b0;
    adder_output = '0;
    fin = 1'b0;
    rd_addr = '0;
    drn_if.out_ready = 1'b0;
    tick();
    check("rst_valid", drn_if.out_valid, 0);
    check("rst_rows", row_count, 0);
    check("rst_done", vector_done, 0);
    check("rst_ovf", overflow_error, 0);
    check("rst_data", drn_if.out_data, 0);
    check("rst_index", drn_if.out_index, 0);
    check("rst_rd", rd_data, 0);

    // Full vector, always-ready drain
    main_reset = 1'b0;
    start = 1'b1;
    tick();
    collect(15, 32'h3F80_0000);
    check("c15_rows", row_count, 15);
    check("c15_valid", drn_if.out_valid, 0);
    collect(1, 32'h3F80_000F);
    check("c16_rows", row_count, 16);
    drain(32'h3F80_0000, 0);
    tick();
    tick();
    check("done_hold", vector_done, 1);
    check("done_hold_v", drn_if.out_valid, 0);

    foreach (rd_tab[i]) begin
      rd_addr = rd_tab[i].addr;
      tick();
      check($sformatf("rd_tab%0d", i), rd_data, rd_tab[i].exp);
    end

    start = 1'b0;
    tick();
    check("idle_done", vector_done, 0);

    // Stalled drain
    start = 1'b1;
    tick();
    collect(16, 32'h4000_0000);
    drain(32'h4000_0000, 1);

    // Overflow during drain
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    collect(16, 32'h3F80_0000);
    adder_output = 32'h0000_0BAD;
    fin = 1'b1;
    tick();
    fin = 1'b0;
    check("ovf_set", overflow_error, 1);
    check("ovf_idx", drn_if.out_index, 0);
    drain(32'h3F80_0000, 0);
    check("ovf_done", overflow_error, 1);
    start = 1'b0;
    tick();
    check("ovf_idle", overflow_error, 1);
    start = 1'b1;
    tick();
    check("ovf_clr", overflow_error, 0);

    // Abort after 5 captures, then restart
    collect(5, 32'h1111_0000);
    check("ab_rows", row_count, 5);
    start = 1'b0;
    tick();
    check("ab_valid", drn_if.out_valid, 0);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    check("idle_pulse", overflow_error, 0);
    start = 1'b1;
    tick();
    check("re_rows", row_count, 0);
    collect(1, 32'h2222_0000);
    rd_addr = 5'd0;
    tick();
    check("re_slot0", rd_data, 32'h2222_0000);
    rd_addr = 5'd1;
    tick();
    check("re_slot1", rd_data, 32'h1111_0001);

    // Same-edge write and read of slot 3
    collect(2, 32'h2222_0001);
    check("rbw_rows", row_count, 3);
    adder_output = 32'hDEAD_BEEF;
    fin = 1'b1;
    rd_addr = 5'd3;
    tick();
    fin = 1'b0;
    check("rbw_old", rd_data, 32'h1111_0003);
    tick();
    check("rbw_new", rd_data, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a drain
    collect(12, 32'h3333_0000);
    check("ar_pre", drn_if.out_valid, 1);
    drn_if.out_ready = 1'b1;
    tick();
    tick();
    drn_if.out_ready = 1'b0;
    check("ar_idx", drn_if.out_index, 2);
    #2;
    main_reset = 1'b1;
    #1;
    check("ar_valid", drn_if.out_valid, 0);
    check("ar_rows", row_count, 0);
    check("ar_data", drn_if.out_data, 0);
    check("ar_rd", rd_data, 0);
    tick();
    main_reset = 1'b0;
    start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
